// File: rtl/mos6502s_bus_arbiter.sv
// Shares the single RAM port between the mos6502s CPU and one DMA requester.
// Optional activity counters are built when ARB_STATS_EN is defined.
module mos6502s_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rdy,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_we,
    output logic                  dma_grant,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            owner
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]           dma_cycles,
    output logic [31:0]           cpu_stall_cycles
`endif
);

    localparam logic [1:0] OWN_CPU  = 2'd0;
    localparam logic [1:0] OWN_DMA  = 2'd1;
    localparam logic [1:0] HANDBACK = 2'd2;

    localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [7:0]            burst_cnt;
    logic [7:0]            burst_nxt;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Bus steering, handshake outputs and next-state selection.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        cpu_rdy   = 1'b0;
        dma_grant = 1'b0;
        dma_ack   = 1'b0;
        case (state)
            OWN_CPU: begin
                mem_re    = cpu_read;
                mem_we    = cpu_write;
                cpu_rdy   = 1'b1;
                burst_nxt = 8'd0;
                // A 6502 write cannot be held, so never grant over it.
                if (dma_req && !cpu_write)
                    state_nxt = OWN_DMA;
            end
            OWN_DMA: begin
                dma_grant = 1'b1;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                if (dma_req) begin
                    dma_ack   = 1'b1;
                    mem_we    = dma_we;
                    mem_re    = ~dma_we;
                    burst_nxt = burst_cnt + 8'd1;
                    // Last allowed transfer: force one CPU cycle.
                    if (burst_cnt == LAST)
                        state_nxt = OWN_CPU;
                end else begin
                    state_nxt = HANDBACK;
                end
            end
            HANDBACK: begin
                burst_nxt = 8'd0;
                state_nxt = OWN_CPU;
            end
            default: begin
                burst_nxt = 8'd0;
                state_nxt = OWN_CPU;
            end
        endcase
    end

    // Ownership state and burst length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= OWN_CPU;
            burst_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Keep the last CPU-side read so a frozen CPU sees stable data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (state == OWN_CPU)
            rdata_q <= mem_rdata;
    end

    assign cpu_rdata = (state == OWN_CPU) ? mem_rdata : rdata_q;
    assign dma_rdata = mem_rdata;
    assign owner     = state;

`ifdef ARB_STATS_EN
    // Count DMA transfers and CPU stall cycles, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_cycles       <= 32'd0;
            cpu_stall_cycles <= 32'd0;
        end else begin
            if (dma_ack)
                dma_cycles <= dma_cycles + 32'd1;
            if (!cpu_rdy)
                cpu_stall_cycles <= cpu_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mos6502s_bus_arbiter.sv
// Self-checking bench for mos6502s_bus_arbiter: directed scenarios plus
// random traffic compared against a behavioural ownership model.
module tb_mos6502s_bus_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_we;
    logic        dma_grant;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [1:0]  owner;
`ifdef ARB_STATS_EN
    logic [31:0] dma_cycles;
    logic [31:0] cpu_stall_cycles;
`endif

    logic [7:0] ram [0:65535];
    assign mem_rdata = ram[mem_addr];

    always #5 clk = ~clk;

    mos6502s_bus_arbiter #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_read (cpu_read),
        .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata),
        .cpu_rdy  (cpu_rdy),
        .dma_req  (dma_req),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_we   (dma_we),
        .dma_grant(dma_grant),
        .dma_ack  (dma_ack),
        .dma_rdata(dma_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .owner    (owner)
`ifdef ARB_STATS_EN
        ,
        .dma_cycles      (dma_cycles),
        .cpu_stall_cycles(cpu_stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the bus, written from the sharing rules.
    bit          m_dma;
    bit          m_bubble;
    int          m_done;
    logic [7:0]  m_hold;
    int unsigned m_dcyc;
    int unsigned m_stall;

    logic       obs_ack;
    logic       obs_grant;
    logic [1:0] obs_own;
    logic [7:0] obs_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, check at mid-cycle, update RAM and model.
    task automatic cyc(input logic cr, input logic cw,
                       input logic [15:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dw,
                       input logic [15:0] da, input logic [7:0] dd);
        logic       e_rdy;
        logic       e_grant;
        logic       e_ack;
        logic       e_re;
        logic       e_we;
        logic [1:0] e_own;
        cpu_read  = cr;
        cpu_write = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        dma_req   = dr;
        dma_we    = dw;
        dma_addr  = da;
        dma_wdata = dd;
        #4;
        if (m_bubble) begin
            e_own = 2'd2; e_rdy = 0; e_grant = 0;
            e_ack = 0; e_re = 0; e_we = 0;
        end else if (m_dma) begin
            e_own = 2'd1; e_rdy = 0; e_grant = 1;
            e_ack = dr; e_re = dr && !dw; e_we = dr && dw;
        end else begin
            e_own = 2'd0; e_rdy = 1; e_grant = 0;
            e_ack = 0; e_re = cr; e_we = cw;
        end
        chk("owner", 32'(owner), 32'(e_own));
        chk("cpu_rdy", 32'(cpu_rdy), 32'(e_rdy));
        chk("dma_grant", 32'(dma_grant), 32'(e_grant));
        chk("dma_ack", 32'(dma_ack), 32'(e_ack));
        chk("mem_re", 32'(mem_re), 32'(e_re));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_own == 2'd0) begin
            chk("cpu_addr_path", 32'(mem_addr), 32'(ca));
            chk("cpu_wdata_path", 32'(mem_wdata), 32'(cd));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(ram[ca]));
        end else begin
            if (e_own == 2'd1) begin
                chk("dma_addr_path", 32'(mem_addr), 32'(da));
                chk("dma_wdata_path", 32'(mem_wdata), 32'(dd));
            end
            chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(m_hold));
        end
        if (e_ack && !dw)
            chk("dma_rdata", 32'(dma_rdata), 32'(ram[da]));
        obs_ack   = dma_ack;
        obs_grant = dma_grant;
        obs_own   = owner;
        obs_rdata = cpu_rdata;
        if (mem_we)
            ram[mem_addr] = mem_wdata;
        m_dcyc  += 32'(e_ack);
        m_stall += 32'(!e_rdy);
        if (m_bubble) begin
            m_bubble = 0;
        end else if (m_dma) begin
            if (dr) begin
                m_done++;
                if (m_done == MB)
                    m_dma = 0;
            end else begin
                m_dma    = 0;
                m_bubble = 1;
            end
        end else begin
            m_hold = ram[ca];
            if (dr && !cw) begin
                m_dma  = 1;
                m_done = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0]  pat;
        logic        rq;
        logic        wr;
        logic        dwr;
        for (int i = 0; i < 65536; i++)
            ram[i] = 8'($urandom);
        ram[16'h1234] = 8'hA5;
        cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        m_dma = 0; m_bubble = 0; m_done = 0; m_hold = 8'd0;
        m_dcyc = 0; m_stall = 0;
        obs_ack = 0; obs_grant = 0; obs_own = 0; obs_rdata = 0;
        #3;
        chk("rst_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_grant", 32'(dma_grant), 32'd0);
        chk("rst_ack", 32'(dma_ack), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        #9 rst = 0;
        @(posedge clk);
        #1;

        // CPU read with no DMA.
        cyc(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0, 8'h0);
        chk("rd_a5", 32'(obs_rdata), 32'hA5);

        // DMA write granted right after a CPU read.
        cyc(1, 0, 16'h0010, 8'h00, 1, 1, 16'h0200, 8'h5A);
        chk("no_grant_yet", 32'(obs_grant), 32'd0);
        cyc(1, 0, 16'h0010, 8'h00, 1, 1, 16'h0200, 8'h5A);
        chk("grant_next", 32'(obs_grant), 32'd1);
        cyc(1, 0, 16'h0010, 8'h00, 0, 1, 16'h0200, 8'h5A);
        cyc(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0, 8'h0);
        chk("ram_0200", 32'(ram[16'h0200]), 32'h5A);

        // Push sequence: three CPU writes hold off the DMA.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 16'(16'h01FD - i), 8'(i + 1), 1, 0, 16'h0300, 8'h0);
            chk("push_no_grant", 32'(obs_grant), 32'd0);
        end
        cyc(1, 0, 16'hFFFE, 8'h00, 1, 0, 16'h0300, 8'h0);
        chk("push_rd_no_grant", 32'(obs_grant), 32'd0);
        cyc(1, 0, 16'hFFFE, 8'h00, 1, 0, 16'h0300, 8'h0);
        chk("push_grant", 32'(obs_grant), 32'd1);
        cyc(1, 0, 16'hFFFE, 8'h00, 0, 0, 16'h0300, 8'h0);
        cyc(1, 0, 16'hFFFE, 8'h00, 0, 0, 16'h0300, 8'h0);

        // Continuous request: bursts of MB with one CPU slot between.
        cyc(1, 0, 16'h0040, 8'h00, 1, 0, 16'h0400, 8'h0);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 16'h0040, 8'h00, 1, 0, 16'(16'h0400 + i), 8'h0);
            pat = {pat[8:0], obs_ack};
        end
        chk("burst_pattern", 32'(pat), 32'b1111011110);
        cyc(1, 0, 16'h0040, 8'h00, 0, 0, 16'h0, 8'h0);
        cyc(1, 0, 16'h0040, 8'h00, 0, 0, 16'h0, 8'h0);
        cyc(1, 0, 16'h0040, 8'h00, 0, 0, 16'h0, 8'h0);

        // Request dropped after two transfers: one handback bubble.
        cyc(1, 0, 16'h0050, 8'h00, 1, 1, 16'h0500, 8'h11);
        cyc(1, 0, 16'h0050, 8'h00, 1, 1, 16'h0500, 8'h11);
        cyc(1, 0, 16'h0050, 8'h00, 1, 1, 16'h0501, 8'h22);
        cyc(1, 0, 16'h0050, 8'h00, 0, 0, 16'h0, 8'h0);
        cyc(1, 0, 16'h0050, 8'h00, 0, 0, 16'h0, 8'h0);
        chk("handback_owner", 32'(obs_own), 32'd2);
        cyc(1, 0, 16'h0050, 8'h00, 0, 0, 16'h0, 8'h0);
        chk("back_to_cpu", 32'(obs_own), 32'd0);

        // Random traffic.
        rq = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0)
                rq = ~rq;
            wr  = ($urandom_range(2) == 0);
            dwr = 1'($urandom);
            cyc(!wr && 1'($urandom), wr, 16'($urandom), 8'($urandom),
                rq, dwr, 16'($urandom), 8'($urandom));
        end

`ifdef ARB_STATS_EN
        chk("stat_dma", dma_cycles, m_dcyc);
        chk("stat_stall", cpu_stall_cycles, m_stall);
`endif

        // Asynchronous reset in the middle of a burst.
        cyc(1, 0, 16'h0060, 8'h00, 0, 0, 16'h0, 8'h0);
        cyc(1, 0, 16'h0060, 8'h00, 0, 0, 16'h0, 8'h0);
        cyc(1, 0, 16'h0060, 8'h00, 1, 0, 16'h0600, 8'h0);
        cyc(1, 0, 16'h0060, 8'h00, 1, 0, 16'h0601, 8'h0);
        cyc(1, 0, 16'h0060, 8'h00, 1, 0, 16'h0602, 8'h0);
        chk("pre_rst_grant", 32'(dma_grant), 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_grant", 32'(dma_grant), 32'd0);
        chk("arst_rdy", 32'(cpu_rdy), 32'd1);
        chk("arst_owner", 32'(owner), 32'd0);
`ifdef ARB_STATS_EN
        chk("arst_stat_dma", dma_cycles, 32'd0);
        chk("arst_stat_stall", cpu_stall_cycles, 32'd0);
`endif
        dma_req = 0;
        #1 rst = 0;
        m_dma = 0; m_bubble = 0; m_done = 0;
        m_dcyc = 0; m_stall = 0;
        m_hold = ram[cpu_addr];
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++)
            cyc(1, 0, 16'(16'h0070 + i), 8'h00, 1, 0, 16'h0700, 8'h0);
        cyc(1, 0, 16'h0080, 8'h00, 0, 0, 16'h0, 8'h0);
        cyc(1, 0, 16'h0080, 8'h00, 0, 0, 16'h0, 8'h0);
`ifdef ARB_STATS_EN
        chk("end_stat_dma", dma_cycles, m_dcyc);
        chk("end_stat_stall", cpu_stall_cycles, m_stall);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
